// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit, ack/data back from memory.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// LEGv8 PC and instruction-fetch stage feeding the control unit.
// Optional feature: define PC_ALIGN_TRAP_EN to trap misaligned jump/branch targets into HALT.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          COUNT_W  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          ps,
    input  logic                ns,
    input  logic [63:0]         k_in,
    input  logic [63:0]         bus_a,
    input  logic                stall,
    pc_fetch_unit_if.master     imem,
    output logic [63:0]         pc,
    output logic [63:0]         pc_plus4,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic [COUNT_W-1:0]  retired,
    output logic                align_fault
);

`ifdef PC_ALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC} state_t;
`endif

    state_t              state_q, state_d;
    logic [63:0]         pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [COUNT_W-1:0]  retired_q, retired_d;
    logic [63:0]         pc_plus4_w;
    logic [63:0]         target_w;
    logic [63:0]         next_pc_w;
    logic                misaligned_w;

`ifdef PC_ALIGN_TRAP_EN
    logic                fault_q, fault_d;
`endif

    assign pc_plus4_w = pc_q + 64'd4;

    always_comb begin
        target_w = pc_q;
        case (ps)
            2'b00:   target_w = pc_q;
            2'b01:   target_w = pc_plus4_w;
            2'b10:   target_w = bus_a;
            default: target_w = pc_plus4_w + (k_in << 2);
        endcase
    end

`ifdef PC_ALIGN_TRAP_EN
    // Only register/branch targets can be misaligned; PC+4 from an aligned PC never is.
    assign misaligned_w = ps[1] && (target_w[1:0] != 2'b00);
    assign next_pc_w    = target_w;
`else
    assign misaligned_w = 1'b0;
    assign next_pc_w    = target_w & ~64'h3;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;
`ifdef PC_ALIGN_TRAP_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misaligned_w) begin
`ifdef PC_ALIGN_TRAP_EN
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                        state_d = ST_HALT;
`endif
                    end else begin
                        pc_d = next_pc_w;
                        // ns=0 marks the last cycle of this instruction: retire and refetch.
                        if (!ns) begin
                            retired_d = retired_q + COUNT_W'(1);
                            valid_d   = 1'b0;
                            state_d   = ST_FETCH;
                        end
                    end
                end
            end
`ifdef PC_ALIGN_TRAP_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

`ifdef PC_ALIGN_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign align_fault = fault_q;
`else
    assign align_fault = 1'b0;
`endif

    // Request is decoded from the state register so an async reset drops it at once.
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_w;
    assign instruction    = instr_q;
    assign instr_valid    = valid_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ps;
    logic        ns;
    logic [63:0] k_in;
    logic [63:0] bus_a;
    logic        stall;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] retired;
    logic        align_fault;

    pc_fetch_unit_if bus_if ();

    pc_fetch_unit #(.RESET_PC(RST_PC), .COUNT_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps          (ps),
        .ns          (ns),
        .k_in        (k_in),
        .bus_a       (bus_a),
        .stall       (stall),
        .imem        (bus_if),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .retired     (retired),
        .align_fault (align_fault)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural view of the fetch stage.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;
    bit          m_boot, m_valid, m_halt, m_fault;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RST_PC;
        m_instr   = 32'h0;
        m_retired = 32'h0;
        m_boot    = 1'b1;
        m_valid   = 1'b0;
        m_halt    = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic model_update(input logic [1:0] s_ps, input logic s_ns, input logic [63:0] s_k,
                                input logic [63:0] s_bus, input logic s_stall, input logic s_ack,
                                input logic [31:0] s_rd);
        logic [63:0] tgt;
        bit          bad;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (!m_valid) begin
            if (s_ack) begin
                m_instr = s_rd;
                m_valid = 1'b1;
            end
        end else if (!s_stall) begin
            case (s_ps)
                2'd0:    tgt = m_pc;
                2'd1:    tgt = m_pc + 64'd4;
                2'd2:    tgt = s_bus;
                default: tgt = m_pc + 64'd4 + s_k * 64'd4;
            endcase
            bad = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
            bad = (s_ps >= 2'd2) && ((tgt % 64'd4) != 64'd0);
`else
            tgt = tgt - (tgt % 64'd4);
`endif
            if (bad) begin
                m_fault = 1'b1;
                m_halt  = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_pc = tgt;
                if (!s_ns) begin
                    m_retired = m_retired + 32'd1;
                    m_valid   = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        bit exp_req;
        exp_req = !m_boot && !m_halt && !m_valid;
        chk_val("pc",          pc,                  m_pc);
        chk_val("imem_addr",   bus_if.imem_addr,    m_pc);
        chk_val("pc_plus4",    pc_plus4,            m_pc + 64'd4);
        chk_val("imem_req",    64'(bus_if.imem_req), 64'(exp_req));
        chk_val("instruction", 64'(instruction),    64'(m_instr));
        chk_val("instr_valid", 64'(instr_valid),    64'(m_valid));
        chk_val("retired",     64'(retired),        64'(m_retired));
        chk_val("align_fault", 64'(align_fault),    64'(m_fault));
    endtask

    // Called at a negedge: drive one cycle of inputs, clock it, check at the next negedge.
    task automatic step(input logic [1:0] s_ps, input logic s_ns, input logic [63:0] s_k,
                        input logic [63:0] s_bus, input logic s_stall, input logic s_ack,
                        input logic [31:0] s_rd);
        ps                = s_ps;
        ns                = s_ns;
        k_in              = s_k;
        bus_a             = s_bus;
        stall             = s_stall;
        bus_if.imem_ack   = s_ack;
        bus_if.imem_rdata = s_rd;
        model_update(s_ps, s_ns, s_k, s_bus, s_stall, s_ack, s_rd);
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] rnd;
        reset             = 1'b1;
        ps                = 2'b00;
        ns                = 1'b0;
        k_in              = 64'h0;
        bus_a             = 64'h0;
        stall             = 1'b0;
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        chk_val("rst_req", 64'(bus_if.imem_req), 64'd0);
        reset = 1'b0;

        // Zero-wait fetch of three sequential instructions.
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h8B020020);
        for (int i = 0; i < 3; i++) begin
            chk_val("seq_addr", bus_if.imem_addr, 64'(i * 4));
            step(2'd1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h8B020020);
            chk_val("seq_instr", 64'(instruction), 64'h8B020020);
            step(2'd1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        end
        chk_val("seq_retired", 64'(retired), 64'd3);

        // Negative branch offset from 0x100.
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h11111111);
        step(2'd2, 1'b0, 64'h0, 64'h100, 1'b0, 1'b0, 32'h0);
        chk_val("br_addr", bus_if.imem_addr, 64'h100);
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h22222222);
        step(2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFE, 64'h0, 1'b0, 1'b0, 32'h0);
        chk_val("cbz_addr", bus_if.imem_addr, 64'h0FC);

        // Two-cycle BL at 0x40.
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h33333333);
        step(2'd2, 1'b0, 64'h0, 64'h40, 1'b0, 1'b0, 32'h0);
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h94000004);
        r0 = m_retired;
        step(2'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0);
        chk_val("bl1_pc", pc, 64'h40);
        chk_val("bl1_req", 64'(bus_if.imem_req), 64'd0);
        chk_val("bl1_link", pc_plus4, 64'h44);
        step(2'd3, 1'b0, 64'h4, 64'h0, 1'b0, 1'b0, 32'h0);
        chk_val("bl2_pc", pc, 64'h54);
        chk_val("bl2_retired", 64'(retired), 64'(r0 + 32'd1));

        // Slow memory, then stalled execute.
        for (int i = 0; i < 3; i++) begin
            step(2'd3, 1'b0, 64'h7, 64'h0, 1'b0, 1'b0, 32'h0);
            chk_val("wait_req", 64'(bus_if.imem_req), 64'd1);
            chk_val("wait_addr", bus_if.imem_addr, 64'h54);
            chk_val("wait_valid", 64'(instr_valid), 64'd0);
        end
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h44444444);
        r0 = m_retired;
        for (int i = 0; i < 2; i++) begin
            step(2'd1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 32'h0);
            chk_val("stall_pc", pc, 64'h54);
            chk_val("stall_retired", 64'(retired), 64'(r0));
        end
        step(2'd1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0);
        chk_val("post_stall_pc", pc, 64'h58);

        // Reset in the middle of a fetch, with a late ack after release.
        chk_val("pre_rst_req", 64'(bus_if.imem_req), 64'd1);
        reset = 1'b1;
        #1;
        chk_val("async_req", 64'(bus_if.imem_req), 64'd0);
        chk_val("async_pc", pc, RST_PC);
        model_reset();
        @(negedge clock);
        check_all();
        reset = 1'b0;
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h55555555);
        chk_val("late_ack_instr", 64'(instruction), 64'h0);
        chk_val("late_ack_valid", 64'(instr_valid), 64'd0);
        chk_val("restart_addr", bus_if.imem_addr, RST_PC);
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h66666666);

        // Misaligned register target.
        step(2'd2, 1'b0, 64'h0, 64'h2003, 1'b0, 1'b0, 32'h0);
`ifdef PC_ALIGN_TRAP_EN
        chk_val("trap_fault", 64'(align_fault), 64'd1);
        chk_val("trap_pc", pc, RST_PC);
        chk_val("trap_req", 64'(bus_if.imem_req), 64'd0);
        step(2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 32'h77777777);
        chk_val("halt_req", 64'(bus_if.imem_req), 64'd0);
        chk_val("halt_valid", 64'(instr_valid), 64'd0);
`else
        chk_val("mask_pc", pc, 64'h2000);
        chk_val("mask_fault", 64'(align_fault), 64'd0);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [63:0] rk;
            logic [63:0] rb;
            rnd = $urandom;
            rk  = {{56{rnd[7]}}, rnd[7:0]};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) rb = rb & ~64'h3;
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rk, rb,
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom);
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
